// File: rtl/nc_pkg.sv
// Shared constants and state type for the neural-core pixel feeder.
package nc_pkg;

  localparam int unsigned N_PIXELS = 49;
  localparam int unsigned PIX_BITS = 8;
  localparam int unsigned W_PIXEL  = 32;
  localparam int unsigned N_LANES  = W_PIXEL / PIX_BITS;
  localparam int unsigned N_WORDS  = (N_PIXELS * PIX_BITS + W_PIXEL - 1) / W_PIXEL;
  localparam int unsigned IDX_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BIAS = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/nc_pixel_pack.sv
// Packs accepted pixels into lanes of a word and emits one registered
// word strobe per completed (or final, partially filled) word.
module nc_pixel_pack #(
  parameter int unsigned PIX_BITS = nc_pkg::PIX_BITS,
  parameter int unsigned W_PIXEL  = nc_pkg::W_PIXEL
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     last,
  input  logic [PIX_BITS-1:0]      pixel,
  output logic                     word_valid,
  output logic [W_PIXEL-1:0]       word,
  output logic [nc_pkg::IDX_W-1:0] word_idx
);

  localparam int unsigned N_LANES = W_PIXEL / PIX_BITS;
  localparam int unsigned LANE_W  = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int unsigned IDX_W   = nc_pkg::IDX_W;

  logic [W_PIXEL-1:0] lane_buf_q, lane_buf_d;
  logic [LANE_W-1:0]  lane_cnt_q, lane_cnt_d;
  logic [IDX_W-1:0]   word_cnt_q, word_cnt_d;
  logic [W_PIXEL-1:0] word_q, word_d;
  logic [IDX_W-1:0]   word_idx_q, word_idx_d;
  logic               word_valid_q, word_valid_d;
  logic [W_PIXEL-1:0] merged;
  logic               full;

  always_comb begin
    lane_buf_d   = lane_buf_q;
    lane_cnt_d   = lane_cnt_q;
    word_cnt_d   = word_cnt_q;
    word_d       = word_q;
    word_idx_d   = word_idx_q;
    word_valid_d = 1'b0;
    merged       = lane_buf_q;
    full         = (lane_cnt_q == LANE_W'(N_LANES - 1)) || last;

    for (int unsigned i = 0; i < N_LANES; i++) begin
      if (lane_cnt_q == LANE_W'(i)) begin
        merged[i*PIX_BITS +: PIX_BITS] = pixel;
      end
    end

    if (clear) begin
      // Word register keeps its last value; only progress is dropped.
      lane_buf_d = '0;
      lane_cnt_d = '0;
      word_cnt_d = '0;
      word_idx_d = '0;
    end else if (push) begin
      if (full) begin
        word_d       = merged;
        word_idx_d   = word_cnt_q;
        word_cnt_d   = word_cnt_q + 1'b1;
        word_valid_d = 1'b1;
        lane_buf_d   = '0;
        lane_cnt_d   = '0;
      end else begin
        lane_buf_d = merged;
        lane_cnt_d = lane_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_buf_q   <= '0;
      lane_cnt_q   <= '0;
      word_cnt_q   <= '0;
      word_q       <= '0;
      word_idx_q   <= '0;
      word_valid_q <= 1'b0;
    end else begin
      lane_buf_q   <= lane_buf_d;
      lane_cnt_q   <= lane_cnt_d;
      word_cnt_q   <= word_cnt_d;
      word_q       <= word_d;
      word_idx_q   <= word_idx_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign word_valid = word_valid_q;
  assign word       = word_q;
  assign word_idx   = word_idx_q;

endmodule

// File: rtl/nc_pixel_feeder.sv
// Streams one image of pixels into the neural core: bias-load pulse,
// packed pixel words, then a done pulse; abortable at any point.
module nc_pixel_feeder #(
  parameter int unsigned N_PIXELS = nc_pkg::N_PIXELS,
  parameter int unsigned PIX_BITS = nc_pkg::PIX_BITS,
  parameter int unsigned W_PIXEL  = nc_pkg::W_PIXEL
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [PIX_BITS-1:0] s_pixel,
  output logic                nc_new_layer,
  output logic                nc_pixel_ready,
  output logic [W_PIXEL-1:0]  nc_pixel_word,
  output logic [3:0]          nc_word_idx,
  output logic                busy,
  output logic                done
);

  import nc_pkg::state_e;
  import nc_pkg::ST_IDLE;
  import nc_pkg::ST_BIAS;
  import nc_pkg::ST_FILL;
  import nc_pkg::ST_DONE;

  localparam int unsigned CNT_W = $clog2(N_PIXELS + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic              s_ready_q, s_ready_d;
  logic              nc_new_layer_q, nc_new_layer_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              hs;
  logic              push;
  logic              last;
  logic              pack_clear;

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    hs         = s_valid && s_ready_q;
    push       = hs && !abort;
    last       = (pix_cnt_q == CNT_W'(N_PIXELS - 1));
    pack_clear = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_BIAS;
          pix_cnt_d  = '0;
          pack_clear = 1'b1;
        end
      end
      ST_BIAS: state_d = ST_FILL;
      ST_FILL: begin
        if (push) begin
          pix_cnt_d = pix_cnt_q + 1'b1;
        end
        // All pixels in means this cycle carries the final word strobe.
        if (pix_cnt_q == CNT_W'(N_PIXELS)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      pix_cnt_d  = '0;
      pack_clear = 1'b1;
    end

    s_ready_d      = (state_d == ST_FILL) && (pix_cnt_d < CNT_W'(N_PIXELS));
    nc_new_layer_d = (state_d == ST_BIAS);
    busy_d         = (state_d != ST_IDLE);
    done_d         = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      pix_cnt_q      <= '0;
      s_ready_q      <= 1'b0;
      nc_new_layer_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pix_cnt_q      <= pix_cnt_d;
      s_ready_q      <= s_ready_d;
      nc_new_layer_q <= nc_new_layer_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  nc_pixel_pack #(
    .PIX_BITS (PIX_BITS),
    .W_PIXEL  (W_PIXEL)
  ) u_pack (
    .clk        (clk),
    .rst        (rst),
    .clear      (pack_clear),
    .push       (push),
    .last       (last),
    .pixel      (s_pixel),
    .word_valid (nc_pixel_ready),
    .word       (nc_pixel_word),
    .word_idx   (nc_word_idx)
  );

  assign s_ready      = s_ready_q;
  assign nc_new_layer = nc_new_layer_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_nc_pixel_feeder.sv
// Directed self-checking bench for nc_pixel_feeder with hand-derived words.
module tb_nc_pixel_feeder;

  logic        clk = 1'b0;
  logic        rst, start, abort, s_valid, s_ready;
  logic [7:0]  s_pixel;
  logic        nc_new_layer, nc_pixel_ready, busy, done;
  logic [31:0] nc_pixel_word;
  logic [3:0]  nc_word_idx;

  nc_pixel_feeder dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_pixel        (s_pixel),
    .nc_new_layer   (nc_new_layer),
    .nc_pixel_ready (nc_pixel_ready),
    .nc_pixel_word  (nc_pixel_word),
    .nc_word_idx    (nc_word_idx),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled 2 time units after each rising edge.
  int          cyc = 0;
  logic [31:0] wq[$];
  int          iq[$];
  int          sq[$];
  int          nl_cnt, done_cnt, nl_cyc, done_cyc, rdy_cyc;
  bit          rdy_seen;

  always @(posedge clk) begin
    cyc++;
    #2;
    if (nc_pixel_ready) begin
      wq.push_back(nc_pixel_word);
      iq.push_back(int'(nc_word_idx));
      sq.push_back(cyc);
    end
    if (nc_new_layer) begin nl_cnt++; nl_cyc = cyc; end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (s_ready && !rdy_seen) begin rdy_seen = 1'b1; rdy_cyc = cyc; end
  end

  task automatic clr_mon();
    wq.delete(); iq.delete(); sq.delete();
    nl_cnt = 0; done_cnt = 0; rdy_seen = 1'b0;
    nl_cyc = -1; done_cyc = -1; rdy_cyc = -1;
  endtask

  task automatic do_start(output int t);
    @(negedge clk);
    start = 1'b1;
    t = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int n, input logic [7:0] base, input bit gaps,
                      input int abort_at, input bit abort_hs, input int restart_at);
    int k = 0;
    int b = 0;
    bit stop = 1'b0;
    while (!stop && k < n && b < 500) begin
      @(negedge clk);
      b++;
      start   = (k == restart_at);
      s_pixel = base + 8'(k);
      if (k == abort_at) begin
        abort   = 1'b1;
        s_valid = abort_hs;
        stop    = 1'b1;
      end else begin
        s_valid = gaps ? (((b * 7) % 5) < 3) : 1'b1;
        if (s_valid && s_ready) k++;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    abort   = 1'b0;
    start   = 1'b0;
    if (b >= 500) chk("feed_budget", 32'(b), 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    int b = 0;
    while (busy && b < 200) begin
      @(negedge clk);
      b++;
    end
    if (busy) chk(tag, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [31:0] exp_word(input logic [7:0] base, input int j);
    logic [31:0] w = '0;
    for (int l = 0; l < 4; l++) begin
      if (4 * j + l < 49) w[8*l +: 8] = base + 8'(4 * j + l);
    end
    return w;
  endfunction

  task automatic check_image(input string tag, input logic [7:0] base);
    chk({tag, "_nstrobe"}, 32'(wq.size()), 32'd13);
    for (int j = 0; j < 13 && j < wq.size(); j++) begin
      chk($sformatf("%s_w%0d", tag, j), wq[j], exp_word(base, j));
      chk($sformatf("%s_i%0d", tag, j), 32'(iq[j]), 32'(j));
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_sready"}, 32'(s_ready), 32'd0);
    chk({tag, "_newlayer"}, 32'(nc_new_layer), 32'd0);
    chk({tag, "_pixready"}, 32'(nc_pixel_ready), 32'd0);
    chk({tag, "_word"}, nc_pixel_word, 32'd0);
    chk({tag, "_idx"}, 32'(nc_word_idx), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached, bench did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    int n;
    rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_pixel = '0;
    clr_mon();
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Back-to-back image 0x01..0x31 with latency checks.
    clr_mon();
    do_start(t);
    chk("bias_pulse", 32'(nc_new_layer), 32'd1);
    chk("bias_busy", 32'(busy), 32'd1);
    chk("bias_sready", 32'(s_ready), 32'd0);
    feed(49, 8'h01, 1'b0, -1, 1'b0, -1);
    chk("b2b_sready_drop", 32'(s_ready), 32'd0);
    wait_idle("b2b_idle");
    chk("b2b_nl_cnt", 32'(nl_cnt), 32'd1);
    chk("b2b_nl_cyc", 32'(nl_cyc), 32'(t + 1));
    chk("b2b_rdy_cyc", 32'(rdy_cyc), 32'(t + 2));
    chk("b2b_w0_cyc", 32'(sq.size() > 0 ? sq[0] : -1), 32'(t + 6));
    chk("b2b_done_cnt", 32'(done_cnt), 32'd1);
    chk("b2b_done_gap", 32'(done_cyc), 32'(sq.size() > 12 ? sq[12] + 1 : -1));
    chk("b2b_done_cyc", 32'(done_cyc), 32'(t + 52));
    chk("b2b_word0", wq.size() > 0 ? wq[0] : 32'hdeadbeef, 32'h04030201);
    chk("b2b_word12", wq.size() > 12 ? wq[12] : 32'hdeadbeef, 32'h00000031);
    check_image("b2b", 8'h01);
    chk("hold_word", nc_pixel_word, 32'h00000031);
    chk("hold_ready", 32'(nc_pixel_ready), 32'd0);

    // Same image with gaps in s_valid.
    clr_mon();
    do_start(t);
    feed(49, 8'h01, 1'b1, -1, 1'b0, -1);
    chk("gap_sready_drop", 32'(s_ready), 32'd0);
    wait_idle("gap_idle");
    check_image("gap", 8'h01);
    chk("gap_done_cnt", 32'(done_cnt), 32'd1);

    // start while busy is ignored.
    clr_mon();
    do_start(t);
    feed(49, 8'h40, 1'b0, -1, 1'b0, 5);
    wait_idle("restart_idle");
    chk("restart_nl_cnt", 32'(nl_cnt), 32'd1);
    chk("restart_done_cnt", 32'(done_cnt), 32'd1);
    check_image("restart", 8'h40);

    // Abort after 10 pixels, then a fresh image 0xA0..0xD0.
    clr_mon();
    do_start(t);
    feed(49, 8'h10, 1'b0, 10, 1'b0, -1);
    chk("abort10_busy", 32'(busy), 32'd0);
    chk("abort10_sready", 32'(s_ready), 32'd0);
    repeat (5) @(negedge clk);
    chk("abort10_nstrobe", 32'(wq.size()), 32'd2);
    chk("abort10_w1", wq.size() > 1 ? wq[1] : 32'hdeadbeef, 32'h17161514);
    chk("abort10_done", 32'(done_cnt), 32'd0);
    clr_mon();
    do_start(t);
    feed(49, 8'hA0, 1'b0, -1, 1'b0, -1);
    wait_idle("new_idle");
    chk("new_word0", wq.size() > 0 ? wq[0] : 32'hdeadbeef, 32'hA3A2A1A0);
    chk("new_idx0", 32'(iq.size() > 0 ? iq[0] : -1), 32'd0);
    check_image("new", 8'hA0);
    chk("new_done_cnt", 32'(done_cnt), 32'd1);

    // Reset during FILL.
    clr_mon();
    do_start(t);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_pixel = 8'h50 + 8'(i);
    end
    @(negedge clk);
    rst = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    check_zero_outputs("midrst");
    rst = 1'b0;
    n = wq.size();
    repeat (60) @(negedge clk);
    chk("midrst_nstrobe", 32'(wq.size()), 32'(n));
    chk("midrst_done", 32'(done_cnt), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);

    // Abort coincident with the final handshake.
    clr_mon();
    do_start(t);
    feed(49, 8'h20, 1'b0, 48, 1'b1, -1);
    chk("abortlast_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    chk("abortlast_nstrobe", 32'(wq.size()), 32'd12);
    chk("abortlast_lastidx", 32'(iq.size() > 0 ? iq[iq.size() - 1] : -1), 32'd11);
    chk("abortlast_done", 32'(done_cnt), 32'd0);

    // start and abort together in IDLE: start wins; then abort in BIAS.
    clr_mon();
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("startwins_nl", 32'(nc_new_layer), 32'd1);
    chk("startwins_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("biasabort_busy", 32'(busy), 32'd0);
    chk("biasabort_sready", 32'(s_ready), 32'd0);
    repeat (5) @(negedge clk);
    chk("biasabort_done", 32'(done_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
